// File: rtl/load_store_unit.sv
// Load/store unit: turns one load or store into a valid/ready data-bus access and returns the extended result.
// Build macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses never reach the bus and complete with rsp_err.
module load_store_unit #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        byt_typ,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              bus_valid,
   input  logic              bus_ready,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_wstrb,
   output logic [31:0]       bus_wdata,
   input  logic              bus_rvalid,
   input  logic [31:0]       bus_rdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_data,
   output logic              rsp_err,
   output logic              stall
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                we_q, we_d;
   size_e               size_q, size_d;
   logic                uns_q, uns_d;
   logic [1:0]          off_q, off_d;
   logic                err_q, err_d;
   logic                req_ready_q, req_ready_d;
   logic                bus_valid_q, bus_valid_d;
   logic                bus_we_q, bus_we_d;
   logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
   logic [STRB_W-1:0]   bus_wstrb_q, bus_wstrb_d;
   logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic                rsp_err_q, rsp_err_d;

   size_e               size_in_c;
   logic                illegal_c;
   logic                trap_c;
   logic [STRB_W-1:0]   strb_c;
   logic [DATA_W-1:0]   lane_c;
   logic [7:0]          byte_c;
   logic [15:0]         half_c;
   logic [DATA_W-1:0]   load_c;
   logic                timeout_c;

   // Request decode: access size, byte strobes and lane-replicated store data
   always_comb begin
      size_in_c = SZ_W;
      illegal_c = 1'b0;
      strb_c    = 4'b1111;
      lane_c    = wdata;
      case (byt_typ)
         3'b000, 3'b100: size_in_c = SZ_B;
         3'b001, 3'b101: size_in_c = SZ_H;
         3'b010:         size_in_c = SZ_W;
         default:        illegal_c = 1'b1;
      endcase
      case (size_in_c)
         SZ_B: begin
            strb_c = 4'b0001 << addr[1:0];
            lane_c = {4{wdata[7:0]}};
         end
         SZ_H: begin
            strb_c = addr[1] ? 4'b1100 : 4'b0011;
            lane_c = {2{wdata[15:0]}};
         end
         default: ;
      endcase
`ifdef LSU_MISALIGN_TRAP_EN
      trap_c = ((size_in_c == SZ_H) && addr[0]) ||
               ((size_in_c == SZ_W) && (addr[1:0] != 2'b00));
`else
      trap_c = 1'b0;
`endif
   end

   // Load extraction from the returned word
   always_comb begin
      byte_c = bus_rdata[7:0];
      case (off_q)
         2'd1:    byte_c = bus_rdata[15:8];
         2'd2:    byte_c = bus_rdata[23:16];
         2'd3:    byte_c = bus_rdata[31:24];
         default: byte_c = bus_rdata[7:0];
      endcase
      half_c = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (size_q)
         SZ_B:    load_c = uns_q ? {24'b0, byte_c} : {{24{byte_c[7]}}, byte_c};
         SZ_H:    load_c = uns_q ? {16'b0, half_c} : {{16{half_c[15]}}, half_c};
         default: load_c = bus_rdata;
      endcase
   end

   // Watchdog fires on the last permitted cycle of S_REQ+S_WAIT
   assign timeout_c = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      size_d      = size_q;
      uns_d       = uns_q;
      off_d       = off_q;
      err_d       = err_q;
      req_ready_d = req_ready_q;
      bus_valid_d = bus_valid_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wstrb_d = bus_wstrb_q;
      bus_wdata_d = bus_wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (req_valid) begin
               we_d        = req_we;
               size_d      = size_in_c;
               uns_d       = byt_typ[2];
               off_d       = addr[1:0];
               err_d       = illegal_c;
               req_ready_d = 1'b0;
               rsp_data_d  = '0;
               if (trap_c) begin
                  state_d     = S_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else begin
                  state_d     = S_REQ;
                  bus_valid_d = 1'b1;
                  bus_we_d    = req_we;
                  bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                  bus_wstrb_d = req_we ? strb_c : '0;
                  bus_wdata_d = req_we ? lane_c : '0;
               end
            end
         end
         S_REQ: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (timeout_c || bus_ready) begin
               bus_valid_d = 1'b0;
               bus_we_d    = 1'b0;
               bus_addr_d  = '0;
               bus_wstrb_d = '0;
               bus_wdata_d = '0;
            end
            if (timeout_c) begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_data_d  = '0;
            end else if (bus_ready) begin
               if (we_q) begin
                  state_d     = S_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = err_q;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (timeout_c) begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_data_d  = '0;
            end else if (bus_rvalid) begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = err_q;
               rsp_data_d  = load_c;
            end
         end
         S_RESP: begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            req_ready_d = 1'b1;
            rsp_valid_d = 1'b0;
            rsp_err_d   = 1'b0;
            rsp_data_d  = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         size_q      <= SZ_W;
         uns_q       <= 1'b0;
         off_q       <= 2'b00;
         err_q       <= 1'b0;
         req_ready_q <= 1'b1;
         bus_valid_q <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wstrb_q <= '0;
         bus_wdata_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         off_q       <= off_d;
         err_q       <= err_d;
         req_ready_q <= req_ready_d;
         bus_valid_q <= bus_valid_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wstrb_q <= bus_wstrb_d;
         bus_wdata_q <= bus_wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign req_ready = req_ready_q;
   assign bus_valid = bus_valid_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wstrb = bus_wstrb_q;
   assign bus_wdata = bus_wdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   // Stall must also cover the accepting cycle, so it looks at req_valid directly
   assign stall     = !req_ready_q || req_valid;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: main instance with default watchdog, second instance with TIMEOUT=4.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_we;
   logic [2:0]  byt_typ;
   logic [31:0] addr, wdata;
   logic        bus_ready, bus_rvalid;
   logic [31:0] bus_rdata;
   logic        req_ready, bus_valid, bus_we, rsp_valid, rsp_err, stall;
   logic [31:0] bus_addr, bus_wdata, rsp_data;
   logic [3:0]  bus_wstrb;

   logic        req_valid_to, bus_ready_to, bus_rvalid_to;
   logic        req_ready_to, bus_valid_to, bus_we_to, rsp_valid_to, rsp_err_to, stall_to;
   logic [31:0] bus_addr_to, bus_wdata_to, rsp_data_to;
   logic [3:0]  bus_wstrb_to;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_W(32), .TIMEOUT(255)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .byt_typ(byt_typ), .addr(addr), .wdata(wdata),
      .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .stall(stall));

   load_store_unit #(.ADDR_W(32), .TIMEOUT(4)) dut_to (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid_to), .req_ready(req_ready_to),
      .req_we(req_we), .byt_typ(byt_typ), .addr(addr), .wdata(wdata),
      .bus_valid(bus_valid_to), .bus_ready(bus_ready_to), .bus_we(bus_we_to), .bus_addr(bus_addr_to),
      .bus_wstrb(bus_wstrb_to), .bus_wdata(bus_wdata_to), .bus_rvalid(bus_rvalid_to), .bus_rdata(bus_rdata),
      .rsp_valid(rsp_valid_to), .rsp_data(rsp_data_to), .rsp_err(rsp_err_to), .stall(stall_to));

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic drive_req(input logic we, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
      req_valid = 1'b1; req_we = we; byt_typ = t; addr = a; wdata = d;
   endtask

   // Full load on the main instance; samples the response cycle
   task automatic run_load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] rd,
                           output logic v, output logic [31:0] d, output logic e);
      bus_ready = 1'b1;
      drive_req(1'b0, t, a, 32'h0);
      cyc(); req_valid = 1'b0;
      cyc();
      bus_rvalid = 1'b1; bus_rdata = rd;
      cyc(); bus_rvalid = 1'b0;
      v = rsp_valid; d = rsp_data; e = rsp_err;
      cyc();
   endtask

   task automatic test_reset();
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
      total++; if (bus_valid !== 1'b0) begin bad++; $display("FAIL rst_bus_valid got=%b exp=0", bus_valid); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall); end
      total++; if (bus_wstrb !== 4'b0000) begin bad++; $display("FAIL rst_wstrb got=%b exp=0000", bus_wstrb); end
      total++; if (rsp_data !== 32'h0) begin bad++; $display("FAIL rst_rsp_data got=%h exp=0", rsp_data); end
      total++; if (req_ready_to !== 1'b1) begin bad++; $display("FAIL rst_req_ready_to got=%b exp=1", req_ready_to); end
   endtask

   task automatic test_store_word();
      bus_ready = 1'b1;
      drive_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL sw_stall_accept got=%b exp=1", stall); end
      cyc(); req_valid = 1'b0;
      total++; if (bus_valid !== 1'b1) begin bad++; $display("FAIL sw_bus_valid got=%b exp=1", bus_valid); end
      total++; if (bus_we !== 1'b1) begin bad++; $display("FAIL sw_bus_we got=%b exp=1", bus_we); end
      total++; if (bus_addr !== 32'h100) begin bad++; $display("FAIL sw_bus_addr got=%h exp=00000100", bus_addr); end
      total++; if (bus_wstrb !== 4'b1111) begin bad++; $display("FAIL sw_wstrb got=%b exp=1111", bus_wstrb); end
      total++; if (bus_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_wdata got=%h exp=deadbeef", bus_wdata); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL sw_rsp_early got=%b exp=0", rsp_valid); end
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL sw_req_ready_busy got=%b exp=0", req_ready); end
      cyc();
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL sw_rsp_valid got=%b exp=1", rsp_valid); end
      total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL sw_rsp_err got=%b exp=0", rsp_err); end
      total++; if (rsp_data !== 32'h0) begin bad++; $display("FAIL sw_rsp_data got=%h exp=0", rsp_data); end
      total++; if (bus_valid !== 1'b0) begin bad++; $display("FAIL sw_bus_drop got=%b exp=0", bus_valid); end
      cyc();
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL sw_rsp_pulse got=%b exp=0", rsp_valid); end
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL sw_req_ready_back got=%b exp=1", req_ready); end
   endtask

   task automatic test_store_byte_half();
      bus_ready = 1'b1;
      drive_req(1'b1, 3'b000, 32'h103, 32'h000000A5);
      cyc(); req_valid = 1'b0;
      total++; if (bus_wstrb !== 4'b1000) begin bad++; $display("FAIL sb_wstrb got=%b exp=1000", bus_wstrb); end
      total++; if (bus_wdata !== 32'hA5A5A5A5) begin bad++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", bus_wdata); end
      total++; if (bus_addr !== 32'h100) begin bad++; $display("FAIL sb_bus_addr got=%h exp=00000100", bus_addr); end
      cyc();
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL sb_rsp_valid got=%b exp=1", rsp_valid); end
      cyc();
      drive_req(1'b1, 3'b001, 32'h10A, 32'h1234BEEF);
      cyc(); req_valid = 1'b0;
      total++; if (bus_wstrb !== 4'b1100) begin bad++; $display("FAIL sh_wstrb got=%b exp=1100", bus_wstrb); end
      total++; if (bus_wdata !== 32'hBEEFBEEF) begin bad++; $display("FAIL sh_wdata got=%h exp=beefbeef", bus_wdata); end
      total++; if (bus_addr !== 32'h108) begin bad++; $display("FAIL sh_bus_addr got=%h exp=00000108", bus_addr); end
      cyc(); cyc();
   endtask

   task automatic test_load_byte();
      logic v, e;
      logic [31:0] d;
      bus_ready = 1'b1;
      drive_req(1'b0, 3'b000, 32'h102, 32'hFFFFFFFF);
      cyc(); req_valid = 1'b0;
      total++; if (bus_wstrb !== 4'b0000) begin bad++; $display("FAIL lb_wstrb got=%b exp=0000", bus_wstrb); end
      total++; if (bus_we !== 1'b0) begin bad++; $display("FAIL lb_bus_we got=%b exp=0", bus_we); end
      bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
      cyc();
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL lb_handshake_rvalid got=%b exp=0", rsp_valid); end
      bus_rdata = 32'h0080FF00;
      cyc(); bus_rvalid = 1'b0;
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL lb_rsp_valid got=%b exp=1", rsp_valid); end
      total++; if (rsp_data !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_data got=%h exp=ffffff80", rsp_data); end
      total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL lb_err got=%b exp=0", rsp_err); end
      cyc();
      run_load(3'b100, 32'h102, 32'h0080FF00, v, d, e);
      total++; if (v !== 1'b1) begin bad++; $display("FAIL lbu_valid got=%b exp=1", v); end
      total++; if (d !== 32'h00000080) begin bad++; $display("FAIL lbu_data got=%h exp=00000080", d); end
      run_load(3'b010, 32'h104, 32'hCAFEF00D, v, d, e);
      total++; if (d !== 32'hCAFEF00D) begin bad++; $display("FAIL lw_data got=%h exp=cafef00d", d); end
      run_load(3'b101, 32'h100, 32'h7F008001, v, d, e);
      total++; if (d !== 32'h00008001) begin bad++; $display("FAIL lhu_data got=%h exp=00008001", d); end
      run_load(3'b000, 32'h101, 32'h00007F00, v, d, e);
      total++; if (d !== 32'h0000007F) begin bad++; $display("FAIL lb_pos_data got=%h exp=0000007f", d); end
   endtask

   task automatic test_bus_stall();
      bus_ready = 1'b0;
      drive_req(1'b0, 3'b001, 32'h106, 32'h0);
      cyc(); req_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         total++; if (bus_valid !== 1'b1) begin bad++; $display("FAIL lh_hold_valid[%0d] got=%b exp=1", i, bus_valid); end
         total++; if (bus_addr !== 32'h104) begin bad++; $display("FAIL lh_hold_addr[%0d] got=%h exp=00000104", i, bus_addr); end
         total++; if (stall !== 1'b1) begin bad++; $display("FAIL lh_hold_stall[%0d] got=%b exp=1", i, stall); end
         cyc();
      end
      bus_ready = 1'b1;
      total++; if (bus_valid !== 1'b1) begin bad++; $display("FAIL lh_valid_at_ready got=%b exp=1", bus_valid); end
      cyc();
      total++; if (bus_valid !== 1'b0) begin bad++; $display("FAIL lh_valid_after got=%b exp=0", bus_valid); end
      cyc();
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL lh_no_rsp_wait got=%b exp=0", rsp_valid); end
      bus_rvalid = 1'b1; bus_rdata = 32'h80010000;
      cyc(); bus_rvalid = 1'b0;
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL lh_rsp_valid got=%b exp=1", rsp_valid); end
      total++; if (rsp_data !== 32'hFFFF8001) begin bad++; $display("FAIL lh_data got=%h exp=ffff8001", rsp_data); end
      cyc();
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL lh_single_pulse got=%b exp=0", rsp_valid); end
   endtask

   task automatic test_illegal_type();
      bus_ready = 1'b1;
      drive_req(1'b1, 3'b011, 32'h108, 32'h12345678);
      cyc(); req_valid = 1'b0;
      total++; if (bus_wstrb !== 4'b1111) begin bad++; $display("FAIL ill_wstrb got=%b exp=1111", bus_wstrb); end
      total++; if (bus_wdata !== 32'h12345678) begin bad++; $display("FAIL ill_wdata got=%h exp=12345678", bus_wdata); end
      cyc();
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL ill_rsp_valid got=%b exp=1", rsp_valid); end
      total++; if (rsp_err !== 1'b1) begin bad++; $display("FAIL ill_rsp_err got=%b exp=1", rsp_err); end
      cyc();
   endtask

   task automatic test_timeout();
      req_valid_to = 1'b1; req_we = 1'b0; byt_typ = 3'b010; addr = 32'h200; wdata = 32'h0;
      cyc(); req_valid_to = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         total++; if (bus_valid_to !== 1'b1) begin bad++; $display("FAIL to_bus_valid[%0d] got=%b exp=1", i, bus_valid_to); end
         total++; if (rsp_valid_to !== 1'b0) begin bad++; $display("FAIL to_rsp_early[%0d] got=%b exp=0", i, rsp_valid_to); end
         cyc();
      end
      total++; if (rsp_valid_to !== 1'b1) begin bad++; $display("FAIL to_rsp_valid got=%b exp=1", rsp_valid_to); end
      total++; if (rsp_err_to !== 1'b1) begin bad++; $display("FAIL to_rsp_err got=%b exp=1", rsp_err_to); end
      total++; if (rsp_data_to !== 32'h0) begin bad++; $display("FAIL to_rsp_data got=%h exp=0", rsp_data_to); end
      total++; if (bus_valid_to !== 1'b0) begin bad++; $display("FAIL to_bus_drop got=%b exp=0", bus_valid_to); end
      bus_rvalid_to = 1'b1; bus_rdata = 32'hAAAA5555;
      cyc();
      total++; if (req_ready_to !== 1'b1) begin bad++; $display("FAIL to_req_ready got=%b exp=1", req_ready_to); end
      cyc(); bus_rvalid_to = 1'b0;
      total++; if (rsp_valid_to !== 1'b0) begin bad++; $display("FAIL to_late_rvalid got=%b exp=0", rsp_valid_to); end
      total++; if (stall_to !== 1'b0) begin bad++; $display("FAIL to_stall_idle got=%b exp=0", stall_to); end
   endtask

   task automatic test_reset_mid_access();
      bus_ready = 1'b0;
      drive_req(1'b0, 3'b010, 32'h300, 32'h0);
      cyc(); req_valid = 1'b0;
      total++; if (bus_valid !== 1'b1) begin bad++; $display("FAIL rma_req_valid got=%b exp=1", bus_valid); end
      #1 rst_n = 1'b0;
      #1;
      total++; if (bus_valid !== 1'b0) begin bad++; $display("FAIL rma_bus_drop got=%b exp=0", bus_valid); end
      cyc(); rst_n = 1'b1;
      bus_ready = 1'b1;
      drive_req(1'b0, 3'b010, 32'h304, 32'h0);
      cyc(); req_valid = 1'b0;
      cyc();
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rma_wait_busy got=%b exp=0", req_ready); end
      #1 rst_n = 1'b0;
      #1;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rma_async_ready got=%b exp=1", req_ready); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL rma_async_stall got=%b exp=0", stall); end
      bus_rvalid = 1'b1; bus_rdata = 32'h55555555;
      cyc(); rst_n = 1'b1;
      cyc();
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rma_no_rsp0 got=%b exp=0", rsp_valid); end
      bus_rvalid = 1'b0;
      cyc();
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rma_no_rsp1 got=%b exp=0", rsp_valid); end
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rma_ready_after got=%b exp=1", req_ready); end
   endtask

   task automatic test_misalign();
      bus_ready = 1'b1;
      drive_req(1'b0, 3'b010, 32'h102, 32'h0);
      cyc(); req_valid = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      total++; if (bus_valid !== 1'b0) begin bad++; $display("FAIL mis_no_bus got=%b exp=0", bus_valid); end
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL mis_rsp_valid got=%b exp=1", rsp_valid); end
      total++; if (rsp_err !== 1'b1) begin bad++; $display("FAIL mis_rsp_err got=%b exp=1", rsp_err); end
      total++; if (rsp_data !== 32'h0) begin bad++; $display("FAIL mis_rsp_data got=%h exp=0", rsp_data); end
      cyc();
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL mis_ready got=%b exp=1", req_ready); end
`else
      total++; if (bus_valid !== 1'b1) begin bad++; $display("FAIL mis_bus_valid got=%b exp=1", bus_valid); end
      total++; if (bus_addr !== 32'h100) begin bad++; $display("FAIL mis_bus_addr got=%h exp=00000100", bus_addr); end
      cyc();
      bus_rvalid = 1'b1; bus_rdata = 32'h11223344;
      cyc(); bus_rvalid = 1'b0;
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL mis_rsp_valid got=%b exp=1", rsp_valid); end
      total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL mis_rsp_err got=%b exp=0", rsp_err); end
      total++; if (rsp_data !== 32'h11223344) begin bad++; $display("FAIL mis_rsp_data got=%h exp=11223344", rsp_data); end
      cyc();
`endif
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; byt_typ = 3'b000; addr = 32'h0; wdata = 32'h0;
      bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
      req_valid_to = 1'b0; bus_ready_to = 1'b0; bus_rvalid_to = 1'b0;
      #12;
      test_reset();
      rst_n = 1'b1;
      cyc();
      test_store_word();
      test_store_byte_half();
      test_load_byte();
      test_bus_stall();
      test_illegal_type();
      test_timeout();
      test_reset_mid_access();
      test_misalign();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL bench_time_limit got=running exp=finished");
      $fatal(1, "time limit");
   end

endmodule
